// File: rtl/fetch_top.sv
// FETCH stage: owns the PC, issues imem requests, fills the F/D register; FETCH_PERF_CNT_EN adds perf counters.
// Latency: 1 cycle from imem_ready to out_valid; 1 instr/cycle on back-to-back hits.
// Backpressure: stall holds PC and F/D; a hit under stall parks in a one-entry skid (HELD, no new request).

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module fetch_top #(
    parameter logic [`ADDR_SIZE-1:0]  RESET_PC  = 32'h0000_1000,
    parameter logic [`INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    is_jump,
    input  logic [`ADDR_SIZE-1:0]   jump_addr,
    input  logic                    branch,
    input  logic [`ADDR_SIZE-1:0]   branch_addr,
    output logic                    imem_req,
    output logic [`ADDR_SIZE-1:0]   imem_addr,
    input  logic                    imem_ready,
    input  logic [`INSTR_SIZE-1:0]  imem_data,
    output logic [`ADDR_SIZE-1:0]   out_pc,
    output logic [`INSTR_SIZE-1:0]  out_instruction,
    output logic                    out_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_wait
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [`ADDR_SIZE-1:0] PC_STEP = `ADDR_SIZE'(4);

    state_t                   state, state_nxt;
    logic [`ADDR_SIZE-1:0]    pc, pc_nxt;
    logic [`ADDR_SIZE-1:0]    sq_addr, sq_addr_nxt;
    logic [`ADDR_SIZE-1:0]    skid_pc, skid_pc_nxt;
    logic [`INSTR_SIZE-1:0]   skid_instr, skid_instr_nxt;
    logic [`ADDR_SIZE-1:0]    fd_pc_nxt;
    logic [`INSTR_SIZE-1:0]   fd_instr_nxt;
    logic                     fd_vld_nxt;

    logic                     redirect;
    logic [`ADDR_SIZE-1:0]    target;
    logic                     req_open;

    // Branch resolves in M and must win even under a decode hazard stall.
    assign redirect = branch | (is_jump & ~stall);
    assign target   = branch ? branch_addr : jump_addr;

    assign imem_req  = ~reset & (state != ST_HELD);
    assign imem_addr = (state == ST_SQUASH) ? sq_addr : pc;
    assign req_open  = imem_req & ~imem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_FETCH;
            pc              <= RESET_PC;
            sq_addr         <= RESET_PC;
            skid_pc         <= '0;
            skid_instr      <= NOP_INSTR;
            out_pc          <= '0;
            out_instruction <= NOP_INSTR;
            out_valid       <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            sq_addr         <= sq_addr_nxt;
            skid_pc         <= skid_pc_nxt;
            skid_instr      <= skid_instr_nxt;
            out_pc          <= fd_pc_nxt;
            out_instruction <= fd_instr_nxt;
            out_valid       <= fd_vld_nxt;
        end
    end

    // The HELD state doubles as the skid-full flag; leaving HELD empties it.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        sq_addr_nxt    = sq_addr;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        fd_pc_nxt      = out_pc;
        fd_instr_nxt   = out_instruction;
        fd_vld_nxt     = out_valid;

        if (redirect) begin
            pc_nxt         = target;
            fd_pc_nxt      = target;
            fd_instr_nxt   = NOP_INSTR;
            fd_vld_nxt     = 1'b0;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
            if (req_open) begin
                // Memory still owes a reply to the old address; keep presenting it.
                state_nxt   = ST_SQUASH;
                sq_addr_nxt = imem_addr;
            end else begin
                state_nxt   = ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_nxt = pc + PC_STEP;
                        if (!stall) begin
                            fd_pc_nxt    = pc;
                            fd_instr_nxt = imem_data;
                            fd_vld_nxt   = 1'b1;
                        end else begin
                            skid_pc_nxt    = pc;
                            skid_instr_nxt = imem_data;
                            state_nxt      = ST_HELD;
                        end
                    end else if (!stall) begin
                        fd_instr_nxt = NOP_INSTR;
                        fd_vld_nxt   = 1'b0;
                    end
                end
                ST_SQUASH: begin
                    if (imem_ready) begin
                        state_nxt = ST_FETCH;
                    end
                    if (!stall) begin
                        fd_instr_nxt = NOP_INSTR;
                        fd_vld_nxt   = 1'b0;
                    end
                end
                ST_HELD: begin
                    if (!stall) begin
                        fd_pc_nxt      = skid_pc;
                        fd_instr_nxt   = skid_instr;
                        fd_vld_nxt     = 1'b1;
                        skid_pc_nxt    = '0;
                        skid_instr_nxt = NOP_INSTR;
                        state_nxt      = ST_FETCH;
                    end
                end
                default: begin
                    state_nxt = ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // F/D is rewritten only when not stalled; a redirect always loads a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
        end else begin
            if (fd_vld_nxt && !stall && !redirect) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (req_open) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_top.md
Name: fetch_top

Overview:
- FETCH stage top level: owns the architectural PC, issues instruction-memory requests and fills the F/D boundary register consumed by decode_top.
- Accepts redirects from decode (jump) and from the M stage (taken branch), and holds under hazard stall.
- Tolerates multi-cycle instruction memory / icache latency through a valid/ready handshake, with a one-entry skid buffer.

Parameters:
- RESET_PC, 32'h0000_1000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into F/D on flush or reset.

Ports:
- clk  in  1  stage clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; F/D register and PC hold while high
- is_jump  in  1  decode jump redirect (combinational from decode)
- jump_addr  in  `ADDR_SIZE  jump target from decode
- branch  in  1  M-stage taken-branch redirect
- branch_addr  in  `ADDR_SIZE  branch target from M stage
- imem_req  out  1  instruction memory request valid
- imem_addr  out  `ADDR_SIZE  request address; stable while imem_req && !imem_ready
- imem_ready  in  1  memory returns imem_data this cycle
- imem_data  in  `INSTR_SIZE  fetched instruction word
- out_pc  out  `ADDR_SIZE  F/D register: PC of out_instruction
- out_instruction  out  `INSTR_SIZE  F/D register: instruction to decode
- out_valid  out  1  F/D register valid; drives decode we

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC, out_pc = 0, out_instruction = NOP_INSTR, out_valid = 0.
  - skid buffer empty; state = FETCH; imem_req forced 0 while reset is high.
- States:
  - FETCH: imem_req = 1, imem_addr = pc.
  - SQUASH: request outstanding, returning data is to be discarded; imem_req = 1, imem_addr = old pc.
  - HELD: skid buffer full, imem_req = 0.
- Redirect selection: branch has priority over is_jump. is_jump is honoured only when stall = 0. branch is honoured regardless of stall.
- Redirect taken (any state):
  - pc <= target next cycle.
  - F/D register loaded with out_instruction = NOP_INSTR, out_valid = 0, out_pc = target.
  - Skid buffer cleared.
  - If the current request is unanswered (imem_req && !imem_ready), state <= SQUASH; otherwise state <= FETCH.
- FETCH, imem_ready = 1, no redirect:
  - stall = 0: F/D <= {pc, imem_data, 1}, pc <= pc + 4, stay in FETCH. Hit throughput is 1 instr/cycle, latency 1 cycle from ready to out_valid.
  - stall = 1: skid <= {pc, imem_data}, pc <= pc + 4, state <= HELD.
- FETCH, imem_ready = 0: hold pc and imem_addr.
  - stall = 0: F/D <= bubble (out_valid = 0, out_instruction = NOP_INSTR, out_pc unchanged).
  - stall = 1: F/D holds.
- SQUASH, imem_ready = 1: discard imem_data, state <= FETCH (pc already holds the target). While stall = 0, F/D gets bubbles.
- HELD:
  - stall = 0: F/D <= skid contents with valid = 1, skid cleared, state <= FETCH.
  - stall = 1: hold everything.
- PC arithmetic: modulo 2^`ADDR_SIZE; 32'hFFFF_FFFC + 4 wraps to 0. Low two bits of targets pass through unchanged (no alignment check).
- Simultaneous events:
  - branch and is_jump together: branch wins.
  - Redirect with imem_ready in the same cycle: the data is dropped and state goes to FETCH, not SQUASH.
  - Reset mid-request: outstanding response is ignored; imem_req low until reset deasserts.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched [31:0] (count of out_valid = 1 loads into F/D) and perf_wait [31:0] (cycles with imem_req && !imem_ready). Both are reset to 0, wrap at 2^32, and have no effect on datapath behaviour.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset, then imem_ready tied 1 with stall = 0 -> first out_valid cycle shows out_pc = 32'h1000, then 32'h1004, 32'h1008 on consecutive cycles.
- imem_ready low 3 cycles at pc = 32'h1004 -> imem_addr stable at 32'h1004, 3 bubbles (out_valid = 0), then out_pc = 32'h1004 with its data.
- stall high 2 cycles while the 32'h1008 data returns -> out_* hold the 32'h1004 instruction; after stall drops, out_pc = 32'h1008 from skid, no instruction lost or duplicated.
- is_jump = 1, jump_addr = 32'h2000 during a pending miss -> returning data discarded, next valid out_pc = 32'h2000; with stall = 1 the jump is ignored until stall = 0.
- branch = 1 to 32'h3000 and is_jump = 1 to 32'h2000 in the same cycle -> next fetch address 32'h3000, F/D flushed to NOP_INSTR.
- Reset asserted while imem_req high and ready low -> outputs return to reset values immediately (async), imem_req = 0, fetch restarts at 32'h1000.
